uart_tx: RTL and testbench

- UART transmitter, 8N1, LSB first; the transmit counterpart of the design's UART receiver, sharing the same CLKS_PER_BIT baud setting (868 = 115200 baud at 100 MHz).
- Takes bytes through a valid/ready write port into a small FIFO and serialises them back to back on serial_out.
- Sits between the byte-producing logic and the board TX pin.
- Exposes its frame state so its encoding matches the receiver's for debug.

---
 rtl/uart_tx_if.sv | 13 +
 rtl/uart_tx.sv | 157 +++++++++++++++
 tb/tb_uart_tx.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte write port of the UART transmitter.
//   i_Byte  - byte to transmit (producer -> transmitter)
//   i_valid - i_Byte is valid this cycle (producer -> transmitter)
//   o_ready - transmitter FIFO can take a byte (transmitter -> producer)
// A byte is transferred on a rising clock edge when i_valid && o_ready.
interface uart_tx_if;
    logic [7:0] i_Byte;
    logic       i_valid;
    logic       o_ready;

    modport master (output i_Byte, output i_valid, input  o_ready);
    modport slave  (input  i_Byte, input  i_valid, output o_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, fed through a small byte FIFO.
// Frames are sent back to back; the frame state encoding matches the
// companion receiver so the two can be compared on a debug bus.
//   clock      - system clock, all state updates on the rising edge
//   reset      - asynchronous, active-low reset
//   wr         - byte write port (uart_tx_if.slave: i_Byte, i_valid, o_ready)
//   serial_out - registered UART line, idles high
//   o_busy     - frame in progress or FIFO non-empty
//   o_done     - one-cycle pulse after each stop bit completes
//   o_level    - FIFO occupancy, 0..FIFO_DEPTH
//   state      - frame state (000 idle, 001 start, 010 data, 011 stop, 111 cleanup)
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    uart_tx_if.slave                      wr,
    output logic                          serial_out,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic [2:0]                    state
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'b000,
        S_START_BIT = 3'b001,
        S_DATA_BITS = 3'b010,
        S_STOP_BIT  = 3'b011,
        S_CLEANUP   = 3'b111
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [2:0]    bit_idx_nxt;
    logic [7:0]    shift_q, shift_d;
    logic          serial_d, done_d;
    logic          terminal;

    // FIFO: pointers carry one extra bit so full and empty are distinguishable
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Ready comes only from the pointer registers, so a same-cycle pop
    // never opens a slot for a push into a full FIFO.
    assign wr.o_ready = !full;
    assign push       = wr.i_valid && !full;
    assign o_level    = wr_ptr - rd_ptr;
    assign o_busy     = (state_q != S_IDLE) || !empty;
    assign state      = state_q;
    assign terminal   = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign bit_idx_nxt = bit_idx_q + 3'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr.i_Byte;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            serial_out <= 1'b1;
            o_done     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            serial_out <= serial_d;
            o_done     <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_out;
        done_d    = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                serial_d  = 1'b1;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!empty) begin
                    pop      = 1'b1;
                    shift_d  = mem[rd_ptr[AW-1:0]];
                    serial_d = 1'b0;
                    state_d  = S_START_BIT;
                end
            end
            S_START_BIT: begin
                if (terminal) begin
                    clk_cnt_d = '0;
                    serial_d  = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = S_DATA_BITS;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_DATA_BITS: begin
                if (terminal) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        serial_d = 1'b1;
                        state_d  = S_STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_nxt;
                        serial_d  = shift_q[bit_idx_nxt];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_STOP_BIT: begin
                if (terminal) begin
                    clk_cnt_d = '0;
                    done_d    = 1'b1;
                    state_d   = S_CLEANUP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_CLEANUP: begin
                serial_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                serial_d = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks uart_tx (CLKS_PER_BIT=4) against a frame-level model
// every cycle, plus directed literal checks; a second instance at
// CLKS_PER_BIT=868 is decoded by a behavioural receiver.
module tb_uart_tx;
    localparam int unsigned C  = 4;
    localparam int unsigned D  = 4;
    localparam int unsigned C2 = 868;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if bus();
    uart_tx_if bus2();

    logic       serial_out, o_busy, o_done;
    logic [2:0] o_level;
    logic [2:0] state;
    logic       serial2, busy2, done2;
    logic [2:0] level2;
    logic [2:0] state2;

    uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clock(clk), .reset(rst_n), .wr(bus), .serial_out(serial_out),
        .o_busy(o_busy), .o_done(o_done), .o_level(o_level), .state(state));

    uart_tx #(.CLKS_PER_BIT(C2), .FIFO_DEPTH(D)) dut2 (
        .clock(clk), .reset(rst_n), .wr(bus2), .serial_out(serial2),
        .o_busy(busy2), .o_done(done2), .o_level(level2), .state(state2));

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model of dut ----------------
    // phase 0 = idle, 1 = in frame (t = cycles since start edge), 2 = cleanup
    logic [7:0]  mq[$];
    int unsigned phase = 0;
    int unsigned t = 0;
    logic [7:0]  cur = '0;

    always @(posedge clk or negedge rst_n) begin
        bit         acc;
        logic [7:0] b;
        if (!rst_n) begin
            mq.delete();
            phase = 0;
            t = 0;
        end else begin
            acc = bus.i_valid && (mq.size() < D);
            b   = bus.i_Byte;
            case (phase)
                0: if (mq.size() > 0) begin
                    cur = mq.pop_front();
                    phase = 1;
                    t = 0;
                end
                1: begin
                    t++;
                    if (t == 10 * C) phase = 2;
                end
                default: phase = 0;
            endcase
            if (acc) mq.push_back(b);
        end
    end

    function automatic logic exp_line();
        int unsigned sym;
        if (phase != 1) return 1'b1;
        sym = t / C;
        if (sym == 0) return 1'b0;
        if (sym <= 8) return cur[sym-1];
        return 1'b1;
    endfunction

    function automatic logic [2:0] exp_state();
        int unsigned sym;
        if (phase == 0) return 3'b000;
        if (phase == 2) return 3'b111;
        sym = t / C;
        if (sym == 0) return 3'b001;
        if (sym <= 8) return 3'b010;
        return 3'b011;
    endfunction

    always @(negedge clk) begin
        check("serial_out", 32'(serial_out), 32'(exp_line()));
        check("o_done",     32'(o_done),     32'(phase == 2));
        check("o_level",    32'(o_level),    32'(mq.size()));
        check("o_ready",    32'(bus.o_ready), 32'(mq.size() < D));
        check("o_busy",     32'(o_busy),     32'(phase != 0 || mq.size() > 0));
        check("state",      32'(state),      32'(exp_state()));
    end

    // ---------------- behavioural receiver on dut2 ----------------
    logic [7:0]  rx_q[$];
    int unsigned starts[$];
    logic [7:0]  rx_byte = '0;
    bit          rx_busy = 1'b0;
    logic        prev2 = 1'b1;
    int unsigned rx_t = 0;
    int unsigned cyc = 0;
    int unsigned n_done2 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_busy = 1'b0;
            prev2 = 1'b1;
        end else begin
            if (rx_busy) begin
                rx_t++;
                if ((rx_t % C2) == C2 / 2 && rx_t / C2 >= 1 && rx_t / C2 <= 8)
                    rx_byte[rx_t / C2 - 1] = serial2;
                if (rx_t == 9 * C2 + C2 / 2) begin
                    rx_q.push_back(rx_byte);
                    rx_busy = 1'b0;
                end
            end else if (prev2 && !serial2) begin
                rx_busy = 1'b1;
                rx_t = 0;
                starts.push_back(cyc);
            end
            prev2 = serial2;
            if (done2) n_done2++;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge after the accepting edge
    // with i_valid still high.
    task automatic push_byte(input logic [7:0] b);
        int unsigned w = 0;
        bus.i_Byte = b;
        bus.i_valid = 1'b1;
        while (!bus.o_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) check("push_timeout", 32'(w), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int unsigned limit);
        int unsigned w = 0;
        while (o_busy && w < limit) begin
            @(negedge clk);
            w++;
        end
        if (w >= limit) check("idle_timeout", 32'(w), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    logic [9:0]  seq;
    int          done_at;
    int unsigned done_cnt;
    int unsigned w;
    logic [7:0]  six [6] = '{8'h01, 8'h82, 8'h43, 8'hC4, 8'h25, 8'hA6};
    logic [7:0]  lb  [3] = '{8'h3C, 8'h00, 8'hFF};

    initial begin
        bus.i_Byte = '0;  bus.i_valid = 1'b0;
        bus2.i_Byte = '0; bus2.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_serial", 32'(serial_out), 32'd1);
        check("rst_level",  32'(o_level),    32'd0);
        check("rst_ready",  32'(bus.o_ready), 32'd1);
        check("rst_busy",   32'(o_busy),     32'd0);
        check("rst_state",  32'(state),      32'd0);

        // single byte 0xA5: line symbols sampled mid-bit
        push_byte(8'hA5);
        bus.i_valid = 1'b0;
        seq = '0; done_at = -1; done_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (i < 40 && (i % 4) == 2) seq[i / 4] = serial_out;
            if (o_done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        check("a5_frame",   32'(seq),      32'(10'b1101001010));
        check("a5_done_at", 32'(done_at),  32'd40);
        check("a5_done_n",  32'(done_cnt), 32'd1);
        check("a5_busy",    32'(o_busy),   32'd0);
        check("a5_level",   32'(o_level),  32'd0);

        // six bytes with i_valid held: five accepted, sixth stalls
        for (int i = 0; i < 5; i++) push_byte(six[i]);
        check("six_level_full", 32'(o_level),     32'd4);
        check("six_ready_low",  32'(bus.o_ready), 32'd0);
        bus.i_Byte = six[5];
        w = 0;
        while (!bus.o_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("six_stall_to", 32'(w < 100), 32'd1);
        check("six_level_pop",  32'(o_level), 32'd3);
        @(negedge clk);
        check("six_level_push", 32'(o_level), 32'd4);
        bus.i_valid = 1'b0;
        wait_idle(500);

        // push during a frame
        push_byte(8'h5A);
        bus.i_valid = 1'b0;
        repeat (12) @(negedge clk);
        push_byte(8'hC3);
        bus.i_valid = 1'b0;
        check("mid_level", 32'(o_level), 32'd1);
        wait_idle(200);

        // reset 15 cycles into a frame with two bytes queued
        push_byte(8'h00);
        push_byte(8'h22);
        push_byte(8'h33);
        bus.i_valid = 1'b0;
        repeat (13) @(posedge clk);
        #2;
        check("pre_rst_line",  32'(serial_out), 32'd0);
        check("pre_rst_level", 32'(o_level),    32'd2);
        rst_n = 1'b0;
        #1;
        check("arst_line",  32'(serial_out), 32'd1);
        check("arst_state", 32'(state),      32'd0);
        check("arst_level", 32'(o_level),    32'd0);
        check("arst_busy",  32'(o_busy),     32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("post_rst_line", 32'(serial_out), 32'd1);
        check("post_rst_busy", 32'(o_busy),     32'd0);

        // loopback at 868 clocks per bit
        for (int i = 0; i < 3; i++) begin
            bus2.i_Byte = lb[i];
            bus2.i_valid = 1'b1;
            @(negedge clk);
        end
        bus2.i_valid = 1'b0;
        w = 0;
        while ((rx_q.size() < 3 || busy2) && w < 30000) begin
            @(negedge clk);
            w++;
        end
        check("lb_timeout", 32'(w < 30000), 32'd1);
        check("lb_count",   32'(rx_q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check("lb_byte", 32'(i < rx_q.size() ? rx_q[i] : 8'hxx), 32'(lb[i]));
        check("lb_done_n",  32'(n_done2), 32'd3);
        check("lb_starts",  32'(starts.size()), 32'd3);
        for (int i = 1; i < 3; i++)
            check("lb_spacing", 32'(i < starts.size() ? starts[i] - starts[i-1] : 0),
                  32'(10 * C2 + 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
